pipe_addsub: RTL

//  Parametrised, pipelined ripple-carry adder/subtractor with a valid/ready handshake.

---
 rtl/pipe_addsub.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pipe_addsub.sv
// Pipelined ripple-carry adder/subtractor: SEG result bits resolved per stage, valid/ready handshake.
// Operand bits not yet consumed shrink by SEG per stage; resolved sum bits grow by SEG per stage.
module pipe_addsub #(
   parameter int WIDTH = 16,
   parameter int SEG   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf
);

   localparam int STAGES = WIDTH / SEG;
   localparam int LAST   = STAGES - 1;

   if (WIDTH % SEG != 0) begin : g_param_check
      $error("pipe_addsub: WIDTH (%0d) must be a multiple of SEG (%0d)", WIDTH, SEG);
   end

   logic [STAGES-1:0] v_vec;

   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam int REM = WIDTH - gi*SEG;   // operand bits still unresolved on entry
      localparam int RES = (gi+1)*SEG;       // result bits resolved after this stage

      logic [REM-1:0] a_in, b_in;
      logic           c_in_s, v_in;
      logic [RES-1:0] res_new;
      logic [SEG:0]   seg_sum;
      logic           load;
      logic           v_q, v_d, cy_q, cy_d;
      logic [RES-1:0] res_q, res_d;

      if (gi == 0) begin : g_head
         assign a_in    = a;
         assign b_in    = sub ? ~b : b;
         assign c_in_s  = sub ? ~c_in : c_in;
         assign v_in    = in_valid;
         assign res_new = seg_sum[SEG-1:0];
      end else begin : g_link
         assign a_in    = g_stage[gi-1].g_fwd.a_q;
         assign b_in    = g_stage[gi-1].g_fwd.b_q;
         assign c_in_s  = g_stage[gi-1].cy_q;
         assign v_in    = g_stage[gi-1].v_q;
         assign res_new = {seg_sum[SEG-1:0], g_stage[gi-1].res_q};
      end

      assign seg_sum = {1'b0, a_in[SEG-1:0]} + {1'b0, b_in[SEG-1:0]} + {{SEG{1'b0}}, c_in_s};

      // A stage can load unless it and every stage downstream of it are full and the sink stalls.
      assign load = (|((~v_vec) >> gi)) || out_ready;

      always_comb begin
         v_d   = v_q;
         cy_d  = cy_q;
         res_d = res_q;
         if (load) begin
            v_d = v_in;
            if (v_in) begin
               cy_d  = seg_sum[SEG];
               res_d = res_new;
            end
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q   <= 1'b0;
            cy_q  <= 1'b0;
            res_q <= '0;
         end else begin
            v_q   <= v_d;
            cy_q  <= cy_d;
            res_q <= res_d;
         end
      end

      assign v_vec[gi] = v_q;

      if (gi < LAST) begin : g_fwd
         logic [REM-SEG-1:0] a_q, a_d, b_q, b_d;

         always_comb begin
            a_d = a_q;
            b_d = b_q;
            if (load && v_in) begin
               a_d = a_in[REM-1:SEG];
               b_d = b_in[REM-1:SEG];
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
            end else begin
               a_q <= a_d;
               b_q <= b_d;
            end
         end
      end else begin : g_tail
         logic ovf_q, ovf_d;

         // Signed overflow: operand signs agree but the result sign differs.
         always_comb begin
            ovf_d = ovf_q;
            if (load && v_in) begin
               ovf_d = (a_in[REM-1] == b_in[REM-1]) && (seg_sum[SEG-1] != a_in[REM-1]);
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ovf_q <= 1'b0;
            end else begin
               ovf_q <= ovf_d;
            end
         end
      end
   end

   assign in_ready  = rst_n && ((|(~v_vec)) || out_ready);
   assign out_valid = v_vec[LAST];
   assign sum       = g_stage[LAST].res_q;
   assign c_out     = g_stage[LAST].cy_q;
   assign ovf       = g_stage[LAST].g_tail.ovf_q;

endmodule
